// File: rtl/axi4_wdrop_resp_gen_pkg.sv
// Shared constants and types for the write-side drop responder.
// The B response codes and the drop-queue entry layout live here.
package axi4_drop_pkg;

    localparam int RESP_W       = 2;
    localparam int DEF_ID_WIDTH = 10;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    // One pending dropped write, sized for the default ID width.
    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0] id;
        logic [RESP_W-1:0]       resp;
    } drop_entry_t;

endpackage

// File: rtl/axi4_wdrop_resp_gen_if.sv
// Bundles the AW bookkeeping, observed W handshake and both B channels.
// slave = the responder, master = the surrounding slave-port logic.
interface axi4_wdrop_resp_gen_if
    import axi4_drop_pkg::*;
#(
    parameter int ID_WIDTH   = 10,
    parameter int USER_WIDTH = 4
);
    logic                  aw_accept;
    logic                  aw_drop;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [RESP_W-1:0]     aw_resp;
    logic                  aw_ready;

    logic                  s_axi4_wvalid;
    logic                  s_axi4_wready;
    logic                  s_axi4_wlast;
    logic                  w_drop_sel;
    logic                  w_order_err;

    logic [ID_WIDTH-1:0]   s_axi4_bid;
    logic [RESP_W-1:0]     s_axi4_bresp;
    logic [USER_WIDTH-1:0] s_axi4_buser;
    logic                  s_axi4_bvalid;
    logic                  s_axi4_bready;

    logic [ID_WIDTH-1:0]   m_axi4_bid;
    logic [RESP_W-1:0]     m_axi4_bresp;
    logic [USER_WIDTH-1:0] m_axi4_buser;
    logic                  m_axi4_bvalid;
    logic                  m_axi4_bready;

    logic                  response_sent;

    modport slave (
        input  aw_accept, aw_drop, aw_id, aw_resp,
        output aw_ready,
        input  s_axi4_wvalid, s_axi4_wready, s_axi4_wlast,
        output w_drop_sel, w_order_err,
        output s_axi4_bid, s_axi4_bresp, s_axi4_buser, s_axi4_bvalid,
        input  s_axi4_bready,
        input  m_axi4_bid, m_axi4_bresp, m_axi4_buser, m_axi4_bvalid,
        output m_axi4_bready,
        output response_sent
    );

    modport master (
        output aw_accept, aw_drop, aw_id, aw_resp,
        input  aw_ready,
        output s_axi4_wvalid, s_axi4_wready, s_axi4_wlast,
        input  w_drop_sel, w_order_err,
        input  s_axi4_bid, s_axi4_bresp, s_axi4_buser, s_axi4_bvalid,
        output s_axi4_bready,
        output m_axi4_bid, m_axi4_bresp, m_axi4_buser, m_axi4_bvalid,
        input  m_axi4_bready,
        input  response_sent
    );

endinterface

// File: rtl/axi4_wdrop_resp_gen_fifo.sv
// Synchronous FIFO with full/empty flags and same-cycle push/pop.
// Push while full and pop while empty are ignored; DEPTH must be a power of 2.
module rab_sync_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]           wr_ptr_q, wr_ptr_d;
    logic [PW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign push_ok  = push_i & ~full_o;
    assign pop_ok   = pop_i & ~empty_o;
    assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
    assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_ok};
    assign data_o   = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/axi4_wdrop_resp_gen.sv
// Write-side drop responder: steers dropped W bursts to the sink and injects
// their B responses into the slave B channel through a lock-safe arbiter.
module axi4_wdrop_resp_gen
    import axi4_drop_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 10,
    parameter int C_AXI_USER_WIDTH = 4,
    parameter int AW_DEPTH         = 8,
    parameter int DROP_DEPTH       = 4
) (
    input  logic                  axi4_aclk,
    input  logic                  axi4_arstn,
    axi4_wdrop_resp_gen_if.slave  bus
);
    localparam int EW = C_AXI_ID_WIDTH + RESP_W;
    localparam int CW = $clog2(DROP_DEPTH) + 1;

    logic                      ord_full, ord_empty, ord_head;
    logic                      ord_push, ord_pop;
    logic                      drop_full, drop_empty, drop_push;
    logic [EW-1:0]             drop_din, drop_dout;
    logic [C_AXI_ID_WIDTH-1:0] inj_id;
    logic [RESP_W-1:0]         inj_resp;
    logic                      aw_ok, w_last_hs, inj_pend, inj_hs, b_hs, sel;
    logic [CW-1:0]             wdone_q, wdone_d;
    logic                      sel_q, lock_q, last_q;

    assign aw_ok     = ~ord_full & ~drop_full;
    assign ord_push  = bus.aw_accept & aw_ok;
    assign drop_push = ord_push & bus.aw_drop;
    assign drop_din  = {bus.aw_id, bus.aw_resp};
    assign w_last_hs = bus.s_axi4_wvalid & bus.s_axi4_wready & bus.s_axi4_wlast;
    assign ord_pop   = w_last_hs & ~ord_empty;

    rab_sync_fifo #(.DATA_WIDTH(1), .DEPTH(AW_DEPTH)) u_order_q (
        .clk_i   (axi4_aclk),
        .rst_ni  (axi4_arstn),
        .push_i  (ord_push),
        .pop_i   (ord_pop),
        .data_i  (bus.aw_drop),
        .data_o  (ord_head),
        .full_o  (ord_full),
        .empty_o (ord_empty)
    );

    rab_sync_fifo #(.DATA_WIDTH(EW), .DEPTH(DROP_DEPTH)) u_drop_q (
        .clk_i   (axi4_aclk),
        .rst_ni  (axi4_arstn),
        .push_i  (drop_push),
        .pop_i   (inj_hs),
        .data_i  (drop_din),
        .data_o  (drop_dout),
        .full_o  (drop_full),
        .empty_o (drop_empty)
    );

    assign {inj_id, inj_resp} = drop_dout;

    // Bursts complete in AW order, so the drop-queue head is always the
    // oldest dropped write whose data has fully drained.
    assign inj_pend = ~drop_empty & (wdone_q != '0);

    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = sel_q;
        end else if (inj_pend && bus.m_axi4_bvalid) begin
            sel = ~last_q;
        end else if (inj_pend) begin
            sel = 1'b1;
        end
    end

    assign inj_hs = sel & bus.s_axi4_bready;
    assign b_hs   = bus.s_axi4_bvalid & bus.s_axi4_bready;

    always_comb begin
        wdone_d = wdone_q;
        case ({ord_pop & ord_head, inj_hs})
            2'b10:   wdone_d = wdone_q + CW'(1);
            2'b01:   wdone_d = wdone_q - CW'(1);
            default: wdone_d = wdone_q;
        endcase
    end

    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wdone_q <= '0;
            sel_q   <= 1'b0;
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            wdone_q <= wdone_d;
            sel_q   <= sel;
            lock_q  <= bus.s_axi4_bvalid & ~bus.s_axi4_bready;
            if (b_hs) begin
                last_q <= sel;
            end
        end
    end

    assign bus.aw_ready      = aw_ok;
    assign bus.w_drop_sel    = ~ord_empty & ord_head;
    assign bus.w_order_err   = w_last_hs & ord_empty;
    assign bus.s_axi4_bvalid = sel ? 1'b1     : bus.m_axi4_bvalid;
    assign bus.s_axi4_bid    = sel ? inj_id   : bus.m_axi4_bid;
    assign bus.s_axi4_bresp  = sel ? inj_resp : bus.m_axi4_bresp;
    assign bus.s_axi4_buser  = sel ? '0       : bus.m_axi4_buser;
    assign bus.m_axi4_bready = ~sel & bus.s_axi4_bready;
    assign bus.response_sent = inj_hs;

endmodule

// File: tb/tb_axi4_wdrop_resp_gen.sv
// Scoreboard bench: stimulus feeds an AW-order model, a negedge monitor
// checks every output against it and pops expected injected responses.
module tb_axi4_wdrop_resp_gen;
    import axi4_drop_pkg::*;

    localparam int IDW = 10;
    localparam int UW  = 4;
    localparam int AWD = 8;
    localparam int DD  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_wdrop_resp_gen_if #(.ID_WIDTH(IDW), .USER_WIDTH(UW)) bus ();

    axi4_wdrop_resp_gen #(
        .C_AXI_ID_WIDTH  (IDW),
        .C_AXI_USER_WIDTH(UW),
        .AW_DEPTH        (AWD),
        .DROP_DEPTH      (DD)
    ) dut (
        .axi4_aclk (clk),
        .axi4_arstn(rst_n),
        .bus       (bus)
    );

    typedef struct {
        bit          drop;
        drop_entry_t e;
    } aw_rec_t;

    int vectors = 0;
    int miscompares = 0;

    aw_rec_t     ordq[$];
    drop_entry_t injq[$];
    int          drops_out = 0;
    int          inj_seen = 0;
    int          bursts_avail = 0;
    bit          prev_stall = 0, last_src = 0, m_hs = 0;
    logic [IDW-1:0] prev_bid;
    logic [1:0]     prev_bresp;
    logic [UW-1:0]  prev_buser;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor and reference model: AWs queue in order, each WLAST retires the
    // oldest AW, retired drops become owed B responses.
    aw_rec_t     mr;
    drop_entry_t me;
    bit          exp_src, wl;
    always @(negedge clk) begin
        if (!rst_n) begin
            ordq.delete();
            injq.delete();
            drops_out  = 0;
            prev_stall = 0;
            last_src   = 0;
            m_hs       = 0;
        end else begin
            wl = bus.s_axi4_wvalid & bus.s_axi4_wready & bus.s_axi4_wlast;
            chk("aw_ready", bus.aw_ready, (ordq.size() < AWD) && (drops_out < DD));
            chk("w_drop_sel", bus.w_drop_sel, (ordq.size() > 0) && ordq[0].drop);
            chk("w_order_err", bus.w_order_err, wl && (ordq.size() == 0));
            chk("s_bvalid", bus.s_axi4_bvalid, bus.m_axi4_bvalid || (injq.size() > 0));
            if (prev_stall) begin
                chk("stall_bid", bus.s_axi4_bid, prev_bid);
                chk("stall_bresp", bus.s_axi4_bresp, prev_bresp);
                chk("stall_buser", bus.s_axi4_buser, prev_buser);
            end
            if (bus.s_axi4_bvalid && bus.s_axi4_bready) begin
                if (!prev_stall) begin
                    exp_src = (injq.size() > 0 && bus.m_axi4_bvalid) ? !last_src
                                                                     : (injq.size() > 0);
                    chk("b_source", bus.response_sent, exp_src);
                end
                if (bus.response_sent) begin
                    chk("inj_m_bready", bus.m_axi4_bready, 1'b0);
                    chk("inj_expected", injq.size() > 0, 1'b1);
                    if (injq.size() > 0) begin
                        me = injq.pop_front();
                        chk("inj_bid", bus.s_axi4_bid, me.id);
                        chk("inj_bresp", bus.s_axi4_bresp, me.resp);
                        chk("inj_buser", bus.s_axi4_buser, 0);
                        drops_out--;
                    end
                    inj_seen++;
                end else begin
                    chk("pass_bid", bus.s_axi4_bid, bus.m_axi4_bid);
                    chk("pass_bresp", bus.s_axi4_bresp, bus.m_axi4_bresp);
                    chk("pass_buser", bus.s_axi4_buser, bus.m_axi4_buser);
                    chk("pass_m_bready", bus.m_axi4_bready, 1'b1);
                end
                last_src = bus.response_sent;
            end else begin
                chk("response_sent_idle", bus.response_sent, 1'b0);
            end
            m_hs = bus.m_axi4_bvalid & bus.m_axi4_bready;
            if (wl && ordq.size() > 0) begin
                mr = ordq.pop_front();
                if (mr.drop) injq.push_back(mr.e);
            end
            if (bus.aw_accept && bus.aw_ready) begin
                mr.drop   = bus.aw_drop;
                mr.e.id   = bus.aw_id;
                mr.e.resp = bus.aw_resp;
                ordq.push_back(mr);
                if (mr.drop) drops_out++;
            end
            prev_stall = bus.s_axi4_bvalid & ~bus.s_axi4_bready;
            prev_bid   = bus.s_axi4_bid;
            prev_bresp = bus.s_axi4_bresp;
            prev_buser = bus.s_axi4_buser;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.aw_accept = 0; bus.aw_drop = 0; bus.aw_id = '0; bus.aw_resp = '0;
        bus.s_axi4_wvalid = 0; bus.s_axi4_wready = 0; bus.s_axi4_wlast = 0;
        bus.m_axi4_bvalid = 0; bus.m_axi4_bid = '0; bus.m_axi4_bresp = '0;
        bus.m_axi4_buser = '0; bus.s_axi4_bready = 0;
    endtask

    task automatic send_aw(bit drop, logic [IDW-1:0] id, logic [1:0] resp);
        bus.aw_accept = 1; bus.aw_drop = drop; bus.aw_id = id; bus.aw_resp = resp;
        tick();
        bus.aw_accept = 0; bus.aw_drop = 0;
        bursts_avail++;
    endtask

    task automatic send_burst(int beats);
        for (int i = 0; i < beats; i++) begin
            bus.s_axi4_wvalid = 1; bus.s_axi4_wready = 1;
            bus.s_axi4_wlast = (i == beats - 1);
            tick();
        end
        bus.s_axi4_wvalid = 0; bus.s_axi4_wready = 0; bus.s_axi4_wlast = 0;
        bursts_avail--;
    endtask

    function automatic logic [1:0] rnd_resp();
        int k;
        k = $urandom_range(2);
        return (k == 0) ? RESP_OKAY : ((k == 1) ? RESP_SLVERR : RESP_DECERR);
    endfunction

    task automatic rnd_step(int p_aw, int p_w, int p_mb, int p_br);
        bit aw;
        aw = ($urandom_range(99) < p_aw) && bus.aw_ready;
        bus.aw_accept = aw;
        bus.aw_drop   = $urandom_range(1);
        bus.aw_id     = IDW'($urandom_range(1023));
        bus.aw_resp   = rnd_resp();
        if (bursts_avail > 0 && $urandom_range(99) < p_w) begin
            bus.s_axi4_wvalid = 1;
            bus.s_axi4_wready = ($urandom_range(3) != 0);
            bus.s_axi4_wlast  = ($urandom_range(2) == 0);
            if (bus.s_axi4_wready && bus.s_axi4_wlast) bursts_avail--;
        end else begin
            bus.s_axi4_wvalid = 0;
            bus.s_axi4_wready = $urandom_range(1);
            bus.s_axi4_wlast  = $urandom_range(1);
        end
        if (aw) bursts_avail++;
        if (!bus.m_axi4_bvalid || m_hs) begin
            bus.m_axi4_bvalid = ($urandom_range(99) < p_mb);
            bus.m_axi4_bid    = IDW'($urandom_range(1023));
            bus.m_axi4_bresp  = 2'($urandom_range(3));
            bus.m_axi4_buser  = UW'($urandom_range(15));
        end
        bus.s_axi4_bready = ($urandom_range(99) < p_br);
        tick();
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (n < budget && !(bursts_avail == 0 && injq.size() == 0 && !bus.m_axi4_bvalid)) begin
            rnd_step(0, 80, 0, 100);
            n++;
        end
        chk("drain_in_budget", n < budget, 1'b1);
        idle_inputs();
        bus.s_axi4_bready = 1;
        tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_aw_ready", bus.aw_ready, 1'b1);
        chk("rst_w_drop_sel", bus.w_drop_sel, 1'b0);
        chk("rst_w_order_err", bus.w_order_err, 1'b0);
        chk("rst_response_sent", bus.response_sent, 1'b0);
        chk("rst_s_bvalid", bus.s_axi4_bvalid, bus.m_axi4_bvalid);
        chk("rst_s_bid", bus.s_axi4_bid, bus.m_axi4_bid);
        chk("rst_m_bready", bus.m_axi4_bready, bus.s_axi4_bready);
    endtask

    initial begin
        int n0;
        idle_inputs();
        rst_n = 0;
        bus.m_axi4_bvalid = 1; bus.m_axi4_bid = 10'h155; bus.s_axi4_bready = 1;
        repeat (3) @(posedge clk);
        sample();
        chk_reset_outputs();
        tick();
        idle_inputs();
        rst_n = 1;
        tick();

        // Single drop with a held-off B.
        send_aw(1, 10'h2A, RESP_DECERR);
        sample();
        chk("single_drop_sel", bus.w_drop_sel, 1'b1);
        tick();
        send_burst(4);
        sample();
        chk("single_bvalid", bus.s_axi4_bvalid, 1'b1);
        chk("single_bid", bus.s_axi4_bid, 10'h2A);
        chk("single_bresp", bus.s_axi4_bresp, RESP_DECERR);
        chk("single_buser", bus.s_axi4_buser, 0);
        chk("single_no_sent", bus.response_sent, 1'b0);
        tick();
        sample();
        chk("single_hold_bid", bus.s_axi4_bid, 10'h2A);
        tick();
        bus.s_axi4_bready = 1;
        sample();
        chk("single_sent", bus.response_sent, 1'b1);
        tick();
        sample();
        chk("single_sel_after", bus.w_drop_sel, 1'b0);
        chk("single_bvalid_after", bus.s_axi4_bvalid, 1'b0);
        tick();

        // Pass / drop / pass interleaving.
        n0 = inj_seen;
        send_aw(0, 10'h001, RESP_OKAY);
        send_aw(1, 10'h002, RESP_SLVERR);
        send_aw(0, 10'h003, RESP_OKAY);
        sample(); chk("il_sel0", bus.w_drop_sel, 1'b0); tick();
        send_burst(2);
        sample(); chk("il_sel1", bus.w_drop_sel, 1'b1); tick();
        send_burst(2);
        sample(); chk("il_sel2", bus.w_drop_sel, 1'b0); tick();
        send_burst(2);
        repeat (3) tick();
        chk("il_inj_count", inj_seen - n0, 1);

        // Contention with random traffic on every channel.
        repeat (400) rnd_step(30, 70, 70, 50);
        drain(3000);

        // Order queue full, then drop queue full.
        for (int i = 0; i < AWD; i++) send_aw(0, IDW'(i), RESP_OKAY);
        sample(); chk("full_order", bus.aw_ready, 1'b0); tick();
        send_burst(1);
        sample(); chk("full_order_freed", bus.aw_ready, 1'b1); tick();
        drain(3000);
        for (int i = 0; i < DD; i++) send_aw(1, IDW'(10'h100 + i), RESP_SLVERR);
        sample(); chk("full_drop", bus.aw_ready, 1'b0); tick();
        drain(3000);

        // WLAST with nothing outstanding.
        bus.s_axi4_wvalid = 1; bus.s_axi4_wready = 1; bus.s_axi4_wlast = 1;
        sample(); chk("order_err_pulse", bus.w_order_err, 1'b1); tick();
        idle_inputs(); bus.s_axi4_bready = 1;
        sample();
        chk("order_err_clear", bus.w_order_err, 1'b0);
        chk("order_err_aw_ready", bus.aw_ready, 1'b1);
        chk("order_err_bvalid", bus.s_axi4_bvalid, 1'b0);
        tick();
        n0 = inj_seen;
        send_aw(1, 10'h3FF, RESP_DECERR);
        send_burst(3);
        repeat (3) tick();
        chk("order_err_then_inj", inj_seen - n0, 1);

        // Reset in the middle of a dropped burst with two drops pending.
        bus.s_axi4_bready = 0;
        send_aw(1, 10'h005, RESP_SLVERR);
        send_aw(1, 10'h006, RESP_DECERR);
        bus.s_axi4_wvalid = 1; bus.s_axi4_wready = 1; bus.s_axi4_wlast = 0;
        tick(); tick();
        #2;
        rst_n = 0;
        idle_inputs();
        bus.m_axi4_bvalid = 1; bus.m_axi4_bid = 10'h077; bus.s_axi4_bready = 1;
        sample();
        chk_reset_outputs();
        tick();
        idle_inputs();
        bus.s_axi4_bready = 1;
        bursts_avail = 0;
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("post_rst_no_b", bus.s_axi4_bvalid, 1'b0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
